// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one fixed-latency sequential divider among
// N_REQ requesters: latches the winner's operands, pulses the divider, returns the quotient.
module divider_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DIV_LATENCY = 11
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  dividend_in,
  input  logic [16*N_REQ-1:0]  divisor_in,
  output logic [N_REQ-1:0]     ack,
  output logic [N_REQ-1:0]     done,
  output logic [7:0]           result,
  output logic                 busy,
  output logic                 div_en,
  output logic [15:0]          div_dividend,
  output logic [15:0]          div_divider,
  input  logic [7:0]           div_quotient
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(DIV_LATENCY + 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_LAST = CW'(DIV_LATENCY - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [IW-1:0]    LAST_RST = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     win_q, win_d;
  logic [IW-1:0]     last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [7:0]        result_q, result_d;
  logic              busy_q, busy_d;
  logic              div_en_q, div_en_d;
  logic [15:0]       dividend_q, dividend_d;
  logic [15:0]       divisor_q, divisor_d;

  logic              win_found_s;
  logic [IW-1:0]     win_s;
  logic [IW-1:0]     idx_s;

  // Scan starting just after the last winner so every requester gets a turn.
  always_comb begin
    win_found_s = 1'b0;
    win_s       = {IW{1'b0}};
    idx_s       = {IW{1'b0}};
    for (int k = 1; k <= N_REQ; k++) begin
      idx_s = IW'((int'(last_q) + k) % N_REQ);
      if (!win_found_s && req[idx_s]) begin
        win_found_s = 1'b1;
        win_s       = idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    ack_d      = {N_REQ{1'b0}};
    done_d     = {N_REQ{1'b0}};
    div_en_d   = 1'b0;
    result_d   = result_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          state_d    = S_ISSUE;
          win_d      = win_s;
          dividend_d = dividend_in[{win_s, 4'b0000} +: 16];
          divisor_d  = divisor_in[{win_s, 4'b0000} +: 16];
          ack_d      = ONE_HOT0 << win_s;
          div_en_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d   = {CW{1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Counter value DIV_LATENCY-1 marks cycle E+DIV_LATENCY.
        if (cnt_q == CNT_LAST) begin
          result_d = div_quotient;
          done_d   = ONE_HOT0 << win_q;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        last_d  = win_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= S_IDLE;
      win_q      <= {IW{1'b0}};
      last_q     <= LAST_RST;
      cnt_q      <= {CW{1'b0}};
      ack_q      <= {N_REQ{1'b0}};
      done_q     <= {N_REQ{1'b0}};
      result_q   <= 8'h00;
      busy_q     <= 1'b0;
      div_en_q   <= 1'b0;
      dividend_q <= 16'h0000;
      divisor_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      div_en_q   <= div_en_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
    end
  end

  assign ack          = ack_q;
  assign done         = done_q;
  assign result       = result_q;
  assign busy         = busy_q;
  assign div_en       = div_en_q;
  assign div_dividend = dividend_q;
  assign div_divider  = divisor_q;

endmodule
